ber_word_gen: RTL
=================

# ber_word_gen

Source-side stimulus generator for the bit-error measurement path. It produces a stream of 12-bit information words from an LFSR. Alongside each word it emits a corrupted "estimated" copy with an exact, programmable number of flipped bits. Its `info_bits`/`esti_bits` outputs drive the Hamming-distance comparator directly, so every word has a known distance. Output uses a valid/ready handshake so a downstream checker can stall it.

## Interface
- No parameters; all widths fixed at 12-bit words.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run. Sampled only in IDLE.
- `seed`  in  12  first information word. 12'h000 is replaced by 12'h001.
- `err_weight`  in  4  bits to flip per word. Values above 12 saturate to 12.
- `n_words`  in  8  words per run. 0 means an empty run.
- `info_bits`  out  12  current information word.
- `esti_bits`  out  12  `info_bits ^ mask`.
- `valid`  out  1  word pair on the outputs is valid.
- `ready`  in  1  consumer accepts the word when `valid && ready`.
- `busy`  out  1  high in SEND.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- States: IDLE, SEND, DONE.
- IDLE
  - On `start`, latch `seed` (0 becomes 1), `min(err_weight,12)` and `n_words`, and clear `rot` to 0.
  - If the latched `n_words` is 0, go to DONE; otherwise go to SEND.
- SEND
  - `valid` is 1; outputs are held stable until the handshake.
  - On `valid && ready`: decrement the remaining count and advance the LFSR and `rot`.
  - If this was the last word, go to DONE.
- DONE: `done` = 1 for one cycle, `valid` = 0, then IDLE.
- LFSR (Fibonacci, x^12+x^6+x^4+x+1)
  - `fb = s[11]^s[5]^s[3]^s[0]`.
  - `next = {s[10:0], fb}`.
  - The first word of a run is the latched seed itself.
- Error mask
  - `base = (13'd1 << w) - 1`, truncated to 12 bits; w = 12 gives 12'hFFF.
  - `mask` = `base` rotated left by `rot` within 12 bits.
  - `rot` steps by +5 mod 12 per accepted word, giving the sequence 0, 5, 10, 3, 8, 1, …
  - Popcount of `mask` always equals w, so the Hamming distance of each pair is exactly w.
- `start` is ignored outside IDLE. Latched inputs do not change mid-run.
- The `err_weight` saturation rule applies at latch time only.

## Timing
- Reset values: state IDLE, `info_bits` = 0, `esti_bits` = 0, `valid` = 0, `busy` = 0, `done` = 0, `rot` = 0, count = 0.
- Start latency: `start` high in cycle t puts `valid` and `busy` high at t+1 with the first word on the outputs.
- Word advance: a handshake at the edge ending cycle k puts the next word on the outputs in cycle k+1 (registered, zero-bubble).
- With `ready` held high, one word is accepted per cycle. N words take N cycles in SEND, followed by 1 cycle of DONE.
- Last handshake in cycle k: `valid` = 0 and `done` = 1 in cycle k+1; back in IDLE at k+2. `start` is accepted at k+2.
- Empty run (`n_words` = 0): `done` at t+1, no `valid`.
- `rst` asserted mid-run: on the next edge all state returns to reset values. The in-flight word is dropped and no `done` is issued.
- `ready` low while `valid` is high: all outputs hold. `ready` is irrelevant when `valid` is low.

## Test plan
- Basic run: reset, then `seed`=12'h001, `err_weight`=3, `n_words`=3, `ready`=1, pulse `start`.
  - Required `info_bits`: 001, 003, 007 in consecutive cycles.
  - Required `esti_bits`: 006, 0E3, C06.
  - Then `done` pulses once.
- Backpressure: same run with `ready` low for 4 cycles on word 2.
  - `info_bits`=003 and `esti_bits`=0E3 held stable while stalled.
  - No word skipped or duplicated; `done` is delayed by exactly 4 cycles.
- Weight extremes: `err_weight`=0 gives `esti_bits`==`info_bits`. `err_weight`=12 and `err_weight`=15 both give `esti_bits` = ~`info_bits` for every word.
- Zero cases: `seed`=0 gives first word 12'h001. `n_words`=0 gives `done` one cycle after `start` with `valid` never asserted.
- Reset mid-run: assert `rst` during word 2 of 5.
  - Next cycle: all outputs 0, `busy`=0, no `done`.
  - A new `start` replays from the seed.
- Long run with the comparator in loop: 200 words, random `ready`, `err_weight`=5.
  - Comparator distance = 5 on every accepted word.
  - `rot` sequence matches 0, 5, 10, 3, 8, 1, 6, 11, 4, 9, 2, 7 repeating.

Source files
------------

// File: rtl/ber_word_gen.sv
// ber_word_gen: LFSR word source for the bit-error measurement path.
// Emits a 12-bit information word and a copy of it with exactly w bits flipped,
// so the Hamming distance between each pair is known ahead of time.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a run (sampled in IDLE only)
//   seed        first information word (0 is replaced by 1)
//   err_weight  bits to flip per word, saturated to 12
//   n_words     words per run, 0 gives an empty run
//   info_bits   current information word
//   esti_bits   info_bits with the error mask applied
//   valid       word pair on the outputs is valid
//   ready       consumer accepts the pair when valid && ready
//   busy        run in progress (SEND)
//   done        one-cycle pulse at the end of a run
module ber_word_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] seed,
   input  logic [3:0]  err_weight,
   input  logic [7:0]  n_words,
   input  logic        ready,
   output logic [11:0] info_bits,
   output logic [11:0] esti_bits,
   output logic        valid,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e      state_q, state_d;
   logic [11:0] lfsr_q, lfsr_d;
   logic [3:0]  weight_q, weight_d;
   logic [7:0]  count_q, count_d;
   logic [3:0]  rot_q, rot_d;

   logic [11:0] lfsr_next;
   logic [3:0]  rot_next;
   logic [12:0] base_wide;
   logic [11:0] base;
   logic [23:0] rot_wide;
   logic [11:0] mask;

   // x^12 + x^6 + x^4 + x + 1, Fibonacci form
   assign lfsr_next = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};

   // rot + 5 mod 12 without widening: rot >= 7 wraps to rot - 7
   assign rot_next = (rot_q >= 4'd7) ? (rot_q - 4'd7) : (rot_q + 4'd5);

   // w low bits set, then rotated left by rot. Rotation keeps popcount == w.
   assign base_wide = (13'd1 << weight_q) - 13'd1;
   assign base      = base_wide[11:0];
   assign rot_wide  = {base, base} << rot_q;
   assign mask      = rot_wide[23:12];

   assign info_bits = lfsr_q;
   assign esti_bits = lfsr_q ^ mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         lfsr_q   <= 12'h000;
         weight_q <= 4'd0;
         count_q  <= 8'd0;
         rot_q    <= 4'd0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         weight_q <= weight_d;
         count_q  <= count_d;
         rot_q    <= rot_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      weight_d = weight_q;
      count_d  = count_q;
      rot_d    = rot_q;
      valid    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               lfsr_d   = (seed == 12'h000) ? 12'h001 : seed;
               weight_d = (err_weight > 4'd12) ? 4'd12 : err_weight;
               count_d  = n_words;
               rot_d    = 4'd0;
               state_d  = (n_words == 8'd0) ? StDone : StSend;
            end
         end
         StSend: begin
            valid = 1'b1;
            busy  = 1'b1;
            if (ready) begin
               count_d = count_q - 8'd1;
               lfsr_d  = lfsr_next;
               rot_d   = rot_next;
               if (count_q == 8'd1) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule
